// File: rtl/grid_pkg.sv
// Shared constants and state encoding for the 28x28 drawing-grid pixel streamer.
package grid_pkg;

    localparam int unsigned GRID_SIZE   = 28;
    localparam int unsigned GRID_CELLS  = GRID_SIZE * GRID_SIZE;
    localparam int unsigned GRID_ADDR_W = 10;
    localparam int unsigned LAST_IDX    = GRID_CELLS - 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } stream_state_e;

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry FIFO of {index, pixel} pairs; the head entry drives the pixel stream.
module stream_skid_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IDX_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [IDX_W-1:0]  push_idx_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [IDX_W-1:0]  head_idx_o,
    output logic [DATA_W-1:0] head_data_o,
    output logic [1:0]        occ_o
);

    logic [IDX_W-1:0]  idx_q  [2];
    logic [DATA_W-1:0] data_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        occ_q;
    logic              do_push;
    logic              do_pop;

    assign do_pop  = pop_i && (occ_q != 2'd0);
    assign do_push = push_i && ((occ_q != 2'd2) || do_pop);

    // Flush only rewinds pointers; stale payload is hidden behind occ_q == 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                idx_q[i]  <= '0;
                data_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else if (flush_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (do_push) begin
                idx_q[wr_ptr_q]  <= push_idx_i;
                data_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            occ_q <= occ_q + 2'(do_push) - 2'(do_pop);
        end
    end

    assign head_idx_o  = idx_q[rd_ptr_q];
    assign head_data_o = data_q[rd_ptr_q];
    assign occ_o       = occ_q;

endmodule

// File: rtl/grid_pixel_streamer.sv
// Reads the 784-cell drawing grid in row-major order and streams it as pixels.
// Optional GRID_INK_COUNT_EN adds an ink_count output (set pixels per frame).
module grid_pixel_streamer
    import grid_pkg::*;
#(
    parameter int unsigned          DATA_W  = 8,
    parameter logic [DATA_W-1:0]    ONE_VAL = DATA_W'(255),
    parameter int unsigned          RD_LAT  = 1
) (
    input  logic                   CLOCK_50,
    input  logic                   resetn,
    input  logic                   start,
    input  logic                   abort,
    output logic [GRID_ADDR_W-1:0] rd_addr,
    output logic                   rd_en,
    input  logic                   rd_data,
    output logic                   pix_valid,
    input  logic                   pix_ready,
    output logic [DATA_W-1:0]      pix_data,
    output logic [GRID_ADDR_W-1:0] pix_index,
    output logic                   pix_last,
    output logic                   busy,
    output logic                   done
`ifdef GRID_INK_COUNT_EN
    ,
    output logic [GRID_ADDR_W-1:0] ink_count
`endif
);

    if (RD_LAT != 1) begin : g_bad_rd_lat
        $error("grid_pixel_streamer: only RD_LAT = 1 is supported");
    end

    stream_state_e          state_q, state_d;
    logic [GRID_ADDR_W-1:0] ptr_q, ptr_d;
    logic                   inflight_q;
    logic [GRID_ADDR_W-1:0] inflight_idx_q;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [1:0]             occ;
    logic [2:0]             resv;
    logic [GRID_ADDR_W-1:0] head_idx;
    logic [DATA_W-1:0]      head_data;
    logic                   xfer;
    logic                   start_acc;
    logic                   flush;
    logic                   push;

    assign pix_valid = (occ != 2'd0);
    assign xfer      = pix_valid && pix_ready;
    assign start_acc = (state_q == IDLE) && start && !abort;
    assign flush     = abort && (state_q != IDLE);
    assign push      = inflight_q && !flush;

    // Slots still claimed after this cycle's pop; keeping it below 2 means the FIFO never overflows.
    assign resv  = 3'(occ) + 3'(inflight_q) - 3'(xfer);
    assign rd_en = (state_q == STREAM) && !abort
                && (ptr_q < GRID_ADDR_W'(GRID_CELLS)) && (resv < 3'd2);

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_acc) state_d = STREAM;
            STREAM: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (xfer && (head_idx == GRID_ADDR_W'(LAST_IDX))) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        ptr_d  = '0;
        if (state_d == STREAM) begin
            busy_d = 1'b1;
            ptr_d  = ptr_q + GRID_ADDR_W'(rd_en);
        end
        if (state_d == DONE) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            ptr_q          <= '0;
            inflight_q     <= 1'b0;
            inflight_idx_q <= '0;
        end else begin
            busy_q         <= busy_d;
            done_q         <= done_d;
            ptr_q          <= ptr_d;
            inflight_q     <= rd_en;
            inflight_idx_q <= ptr_q;
        end
    end

    stream_skid_fifo #(
        .DATA_W (DATA_W),
        .IDX_W  (GRID_ADDR_W)
    ) u_fifo (
        .clk         (CLOCK_50),
        .rst_n       (resetn),
        .flush_i     (flush),
        .push_i      (push),
        .push_idx_i  (inflight_idx_q),
        .push_data_i (rd_data ? ONE_VAL : '0),
        .pop_i       (xfer),
        .head_idx_o  (head_idx),
        .head_data_o (head_data),
        .occ_o       (occ)
    );

    assign rd_addr   = ptr_q;
    assign pix_data  = head_data;
    assign pix_index = head_idx;
    assign pix_last  = pix_valid && (head_idx == GRID_ADDR_W'(LAST_IDX));
    assign busy      = busy_q;
    assign done      = done_q;

`ifdef GRID_INK_COUNT_EN
    logic [GRID_ADDR_W-1:0] ink_q;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            ink_q <= '0;
        end else if (start_acc) begin
            ink_q <= '0;
        end else if (xfer && (head_data == ONE_VAL)) begin
            ink_q <= ink_q + GRID_ADDR_W'(1);
        end
    end

    assign ink_count = ink_q;
`endif

endmodule

// File: tb/tb_grid_pixel_streamer.sv
// Self-checking bench for grid_pixel_streamer: frame table plus stall, abort and reset sequences.
module tb_grid_pixel_streamer;
    import grid_pkg::*;

    logic       CLOCK_50  = 1'b0;
    logic       resetn    = 1'b0;
    logic       start     = 1'b0;
    logic       abort     = 1'b0;
    logic       rd_data   = 1'b0;
    logic       pix_ready = 1'b0;
    logic       rd_en, pix_valid, pix_last, busy, done;
    logic [9:0] rd_addr, pix_index;
    logic [7:0] pix_data;
`ifdef GRID_INK_COUNT_EN
    logic [9:0] ink_count;
`endif

    grid_pixel_streamer dut (
        .CLOCK_50  (CLOCK_50),
        .resetn    (resetn),
        .start     (start),
        .abort     (abort),
        .rd_addr   (rd_addr),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_data  (pix_data),
        .pix_index (pix_index),
        .pix_last  (pix_last),
        .busy      (busy),
        .done      (done)
`ifdef GRID_INK_COUNT_EN
        ,
        .ink_count (ink_count)
`endif
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Grid memory model with one-cycle read latency.
    logic grid [GRID_CELLS];
    int   rd_cnt = 0;

    always @(posedge CLOCK_50) begin
        if (rd_en) begin
            rd_data <= grid[rd_addr];
            rd_cnt  <= rd_cnt + 1;
        end
    end

    typedef struct packed {
        logic [9:0] idx;
        logic [7:0] data;
        logic       last;
    } exp_t;

    typedef struct {
        int pat;
        int rnd;
        int exp_cycles;
        int exp_ones;
    } vec_t;

    exp_t exp_q[$];
    vec_t tbl[6];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic load_pattern(input int pat);
        for (int i = 0; i < int'(GRID_CELLS); i++) begin
            case (pat)
                1:       grid[i] = (i == 5 * 28 + 3);
                2:       grid[i] = (((i % 28) + (i / 28)) % 2) == 1;
                3:       grid[i] = 1'($urandom_range(0, 1));
                4:       grid[i] = 1'b1;
                default: grid[i] = 1'b0;
            endcase
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {rd_en, rd_addr, pix_valid, pix_data, pix_index, pix_last, busy, done}, 64'd0);
    endtask

    // kill: 0 = run to completion, 1 = abort at kill_idx, 2 = async reset at kill_idx.
    task automatic run_frame(input int rnd, input int stall, input int kill, input int kill_idx,
                             input int exp_cycles, input int exp_ones_in);
        int   cyc, nx, ones, rd_base, done_cyc, exp_ones, saw_done;
        logic hold;
        exp_t prev, cur, e;

        exp_q.delete();
        exp_ones = 0;
        for (int i = 0; i < int'(GRID_CELLS); i++) begin
            exp_q.push_back({10'(i), grid[i] ? 8'd255 : 8'd0, i == 783});
            if (grid[i]) exp_ones++;
        end
        if (exp_ones_in >= 0) exp_ones = exp_ones_in;

        rd_base = rd_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1);

        cyc = 0; nx = 0; ones = 0; done_cyc = -1; hold = 1'b0; prev = '0;
        while (cyc < 5000) begin
            if (done) begin
                done_cyc = cyc;
                break;
            end
            cur = {pix_index, pix_data, pix_last};
            if (hold) check("hold_stable", {pix_valid, cur}, {1'b1, prev});
            if (stall > 0 && cyc == stall) begin
                check("stall_reads_le2", (rd_cnt - rd_base) <= 2, 1);
                check("stall_head", {pix_valid, pix_index}, {1'b1, 10'd0});
            end
            if (kill != 0 && pix_valid && pix_index == 10'(kill_idx)) begin
                if (kill == 1) begin
                    abort = 1'b1;
                    tick();
                    abort = 1'b0;
                    check("abort_idle", {rd_en, pix_valid, busy, done}, 64'd0);
                    saw_done = 0;
                    for (int k = 0; k < 5; k++) begin
                        tick();
                        if (done || busy || pix_valid) saw_done++;
                    end
                    check("abort_quiet", saw_done, 0);
                end else begin
                    #2 resetn = 1'b0;
                    #1 check_reset_outputs("midframe_reset");
                    tick();
                    check_reset_outputs("reset_held");
                    #3 resetn = 1'b1;
                    tick();
                    check_reset_outputs("after_release");
                end
                exp_q.delete();
                return;
            end
            pix_ready = (cyc < stall) ? 1'b0 : (rnd != 0 ? 1'($urandom_range(0, 1)) : 1'b1);
            if (pix_valid && pix_ready) begin
                if (exp_q.size() == 0) begin
                    check("xfer_overrun", nx + 1, 784);
                end else begin
                    e = exp_q.pop_front();
                    check("pixel", cur, e);
                end
                nx++;
                if (pix_data == 8'd255) ones++;
            end
            hold = pix_valid && !pix_ready;
            prev = cur;
            tick();
            cyc++;
        end

        check("done_seen", done_cyc >= 0, 1);
        if (exp_cycles > 0) check("done_cycle", done_cyc, exp_cycles);
        check("xfer_count", nx, 784);
        check("ones_count", ones, exp_ones);
        check("read_count", rd_cnt - rd_base, 784);
        check("busy_low_at_done", busy, 0);
`ifdef GRID_INK_COUNT_EN
        check("ink_count", ink_count, exp_ones);
`endif
        tick();
        check("done_one_cycle", {done, busy, pix_valid}, 64'd0);
    endtask

    initial begin
        tbl[0] = '{pat: 0, rnd: 0, exp_cycles: 786, exp_ones: 0};
        tbl[1] = '{pat: 1, rnd: 0, exp_cycles: 786, exp_ones: 1};
        tbl[2] = '{pat: 2, rnd: 1, exp_cycles: 0,   exp_ones: 392};
        tbl[3] = '{pat: 2, rnd: 0, exp_cycles: 786, exp_ones: 392};
        tbl[4] = '{pat: 4, rnd: 0, exp_cycles: 786, exp_ones: 784};
        tbl[5] = '{pat: 3, rnd: 1, exp_cycles: 0,   exp_ones: -1};

        #2 check_reset_outputs("power_on_reset");
        repeat (2) @(posedge CLOCK_50);
        #3 resetn = 1'b1;
        tick();
        check_reset_outputs("idle_after_reset");

        for (int v = 0; v < 6; v++) begin
            load_pattern(tbl[v].pat);
            run_frame(tbl[v].rnd, 0, 0, 0, tbl[v].exp_cycles, tbl[v].exp_ones);
        end

        // Sink stalled for 100 cycles, then released.
        load_pattern(2);
        run_frame(0, 100, 0, 0, 884, 392);

        // Abort mid-frame, then a clean frame from index 0.
        load_pattern(3);
        run_frame(0, 0, 1, 400, 0, -1);
        load_pattern(1);
        run_frame(0, 0, 0, 0, 786, 1);

        // Asynchronous reset mid-frame, then a clean frame.
        load_pattern(2);
        run_frame(1, 0, 2, 500, 0, -1);
        load_pattern(2);
        run_frame(0, 0, 0, 0, 786, 392);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
